// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - freeze/flush sequencer for the 5-stage pipeline latches and PC
//
// Decides each cycle which pipeline latches capture, capture a bubble, or hold.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   ihit, dhit           instruction / data cache hit this cycle
//   mm_dacc              MM stage holds a load or store
//   ex_dREN, ex_rd       EX stage load flag and destination register
//   id_rs, id_rt         ID stage source registers
//   mm_br_taken          MM stage branch/jump resolved taken
//   mm_halt              MM stage holds HALT
//   pc_en, pc_redirect   PC capture enable, PC selects MM-stage target
//   *_en, *_flush        latch capture enables and bubble-capture controls
//   halt_out             core halted (sticky until RST)
//   err                  data-wait watchdog tripped (sticky until RST)
//   stall_cnt, flush_cnt 32-bit perf counters (PIPE_PERF_CNT_EN only)

module pipe_hazard_ctrl #(
  parameter int DWAIT_MAX = 64,
  parameter int REG_W     = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mm_dacc,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             mm_br_taken,
  input  logic             mm_halt,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmm_en,
  output logic             mmwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmm_flush,
  output logic             halt_out,
  output logic             err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DWAIT, FLUSH_PEND, HALTED} state_t;

  localparam int CNT_W = $clog2(DWAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             set_err;
  logic             load_use;

  assign load_use = ex_dREN && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    set_err      = 1'b0;
    pc_en        = 1'b0;
    pc_redirect  = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmm_en      = 1'b0;
    mmwb_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmm_flush   = 1'b0;

    unique case (state)
      RUN: begin
        if (mm_halt) begin
          // Let HALT reach MM/WB, then stop everything.
          {pc_en, ifid_en, idex_en, exmm_en, mmwb_en} = '1;
          state_nxt = HALTED;
        end else if (mm_br_taken && ihit) begin
          // Branch wins over load-use: the flush kills the ID stage anyway.
          {pc_en, pc_redirect, ifid_en, idex_en, exmm_en, mmwb_en} = '1;
          {ifid_flush, idex_flush, exmm_flush} = '1;
        end else if (mm_br_taken) begin
          state_nxt = FLUSH_PEND;
        end else if (mm_dacc && !dhit) begin
          state_nxt    = DWAIT;
          wait_cnt_nxt = CNT_ONE;
        end else begin
          pc_en      = !load_use && ihit;
          ifid_en    = !load_use;
          ifid_flush = !load_use && !ihit;
          idex_en    = 1'b1;
          idex_flush = load_use;
          exmm_en    = 1'b1;
          mmwb_en    = 1'b1;
        end
      end
      DWAIT: begin
        if (dhit) begin
          pc_en        = !load_use && ihit;
          ifid_en      = !load_use;
          ifid_flush   = !load_use && !ihit;
          idex_en      = 1'b1;
          idex_flush   = load_use;
          exmm_en      = 1'b1;
          mmwb_en      = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = (wait_cnt == CNT_MAX) ? CNT_MAX : wait_cnt + 1'b1;
          set_err      = (wait_cnt_nxt == CNT_MAX);
        end
      end
      FLUSH_PEND: begin
        if (ihit) begin
          {pc_en, pc_redirect, ifid_en, idex_en, exmm_en, mmwb_en} = '1;
          {ifid_flush, idex_flush, exmm_flush} = '1;
          state_nxt = RUN;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: state_nxt = RUN;
    endcase

    // Reset forces every latch to capture nothing and present bubbles.
    if (RST) begin
      {pc_en, pc_redirect, ifid_en, idex_en, exmm_en, mmwb_en} = '0;
      {ifid_flush, idex_flush, exmm_flush} = '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      wait_cnt <= '0;
      halt_out <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == HALTED) halt_out <= 1'b1;
      if (set_err)             err      <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // pc_redirect is only ever raised together with the branch-flush pattern.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (state != HALTED)) stall_cnt <= stall_cnt + 32'd1;
      if (pc_redirect)                 flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

  localparam int DWAIT_MAX = 64;
  localparam int REG_W     = 5;

  // Output vector order: pc_en, pc_redirect, ifid_en, idex_en, exmm_en, mmwb_en,
  //                      ifid_flush, idex_flush, exmm_flush
  localparam logic [8:0] P_RESET  = 9'b0_0_0000_111;
  localparam logic [8:0] P_FREEZE = 9'b0_0_0000_000;
  localparam logic [8:0] P_ADV    = 9'b1_0_1111_000;
  localparam logic [8:0] P_BRFL   = 9'b1_1_1111_111;
  localparam logic [8:0] P_LU     = 9'b0_0_0111_010;
  localparam logic [8:0] P_IMISS  = 9'b0_0_1111_100;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit, mm_dacc, ex_dREN, mm_br_taken, mm_halt;
  logic [REG_W-1:0] ex_rd, id_rs, id_rt;
  logic             pc_en, pc_redirect, ifid_en, idex_en, exmm_en, mmwb_en;
  logic             ifid_flush, idex_flush, exmm_flush, halt_out, err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]      stall_cnt, flush_cnt;
`endif

  logic [8:0] out_vec;
  assign out_vec = {pc_en, pc_redirect, ifid_en, idex_en, exmm_en, mmwb_en,
                    ifid_flush, idex_flush, exmm_flush};

  int checks = 0;
  int errors = 0;

  // Model state: what the pipeline is doing, in plain terms.
  bit m_halted   = 1'b0;
  bit m_br_wait  = 1'b0;
  int m_miss_len = 0;
  bit m_err      = 1'b0;

  pipe_hazard_ctrl #(.DWAIT_MAX(DWAIT_MAX), .REG_W(REG_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mm_dacc(mm_dacc),
    .ex_dREN(ex_dREN), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .mm_br_taken(mm_br_taken), .mm_halt(mm_halt),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmm_en(exmm_en), .mmwb_en(mmwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmm_flush(exmm_flush), .halt_out(halt_out), .err(err)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] advance_pattern();
    bit lu;
    lu = ex_dREN && (ex_rd != 0) && (ex_rd == id_rs || ex_rd == id_rt);
    if (lu)    return P_LU;
    if (!ihit) return P_IMISS;
    return P_ADV;
  endfunction

  function automatic logic [8:0] model_out();
    if (RST)            return P_RESET;
    if (m_halted)       return P_FREEZE;
    if (m_miss_len > 0) return dhit ? advance_pattern() : P_FREEZE;
    if (m_br_wait)      return ihit ? P_BRFL : P_FREEZE;
    if (mm_halt)        return P_ADV;
    if (mm_br_taken)    return ihit ? P_BRFL : P_FREEZE;
    if (mm_dacc && !dhit) return P_FREEZE;
    return advance_pattern();
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_halted = 1'b0; m_br_wait = 1'b0; m_miss_len = 0; m_err = 1'b0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_miss_len > 0) begin
      if (dhit) m_miss_len = 0;
      else begin
        m_miss_len++;
        if (m_miss_len >= DWAIT_MAX) m_err = 1'b1;
      end
    end else if (m_br_wait) begin
      if (ihit) m_br_wait = 1'b0;
    end else if (mm_halt) begin
      m_halted = 1'b1;
    end else if (mm_br_taken) begin
      if (!ihit) m_br_wait = 1'b1;
    end else if (mm_dacc && !dhit) begin
      m_miss_len = 1;
    end
  end

  always @(negedge CLK) begin
    check("model_outputs", out_vec, model_out());
    check("model_halt_err", {7'd0, halt_out, err}, {7'd0, m_halted, m_err});
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string nm, input logic [8:0] exp);
    #2;
    check(nm, out_vec, exp);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b1; dhit = 1'b0; mm_dacc = 1'b0; ex_dREN = 1'b0;
    mm_br_taken = 1'b0; mm_halt = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0;
    tick(2);
    lit("reset_pattern", P_RESET);
    check("reset_halt_err", {7'd0, halt_out, err}, 9'd0);
    RST = 1'b0;
    tick(2);
    lit("normal_adv", P_ADV);

    // Load-use on rs, then release
    ex_dREN = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
    lit("load_use_rs", P_LU);
    tick(); ex_dREN = 1'b0;
    lit("after_load_use", P_ADV);
    tick(); ex_dREN = 1'b1; ex_rd = 5'd9; id_rs = 5'd1; id_rt = 5'd9;
    lit("load_use_rt", P_LU);
    tick(); ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    lit("rd_zero_no_stall", P_ADV);
    tick(); ex_dREN = 1'b0;

    // Instruction cache miss
    ihit = 1'b0;
    lit("imiss", P_IMISS);
    tick(); ihit = 1'b1;

    // 5-cycle data miss
    mm_dacc = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lit("dmiss_freeze", P_FREEZE);
      tick();
    end
    dhit = 1'b1;
    lit("dmiss_release", P_ADV);
    tick(); mm_dacc = 1'b0;
    check("dmiss_no_err", {8'd0, err}, 9'd0);

    // Branch with icache miss
    mm_br_taken = 1'b1; ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lit("br_pend_freeze", P_FREEZE);
      tick();
    end
    ihit = 1'b1;
    lit("br_pend_flush", P_BRFL);
    tick(); mm_br_taken = 1'b0;
    lit("after_branch", P_ADV);
    tick();

    // Branch plus load-use: branch wins
    mm_br_taken = 1'b1; ex_dREN = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    lit("br_beats_lu", P_BRFL);
    tick(); mm_br_taken = 1'b0; ex_dREN = 1'b0;

    // Load-use arriving together with a dhit release from DWAIT
    mm_dacc = 1'b1; dhit = 1'b0;
    tick(2);
    dhit = 1'b1; ex_dREN = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    lit("dwait_release_lu", P_LU);
    tick(); mm_dacc = 1'b0; ex_dREN = 1'b0;

    // Watchdog: 70 unserviced cycles
    mm_dacc = 1'b1; dhit = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      check("watchdog_err", {8'd0, err}, {8'd0, (i >= DWAIT_MAX)});
    end
    dhit = 1'b1;
    tick(); mm_dacc = 1'b0;
    check("err_sticky", {8'd0, err}, 9'd1);
    RST = 1'b1;
    tick(); RST = 1'b0;
    check("err_cleared", {8'd0, err}, 9'd0);

    // Halt
    tick();
    mm_halt = 1'b1;
    lit("halt_advance", P_ADV);
    check("halt_not_yet", {8'd0, halt_out}, 9'd0);
    tick(); mm_halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mm_br_taken = i[0]; mm_dacc = i[1]; ihit = i[2];
      lit("halted_freeze", P_FREEZE);
      check("halted_flag", {8'd0, halt_out}, 9'd1);
      tick();
    end
    mm_br_taken = 1'b0; mm_dacc = 1'b0; ihit = 1'b1;
    RST = 1'b1;
    tick(); RST = 1'b0;
    lit("after_halt_reset", P_ADV);
    check("halt_cleared", {8'd0, halt_out}, 9'd0);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
